regf_arbiter: RTL

- Arbitrates NUM_REQ requesters onto the single write port and single read port of the team's register file (one access per clock).
- Sequences a zero-fill of every register-file entry after reset, before it grants any access.
- Sits between client blocks and the register file. Drives the register file's wr_en, w_addr, r_addr and w_data, and samples its combinational r_data.

---
 rtl/regf_arbiter_if.sv | 18 +
 rtl/regf_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/regf_arbiter_if.sv
// Client-side bus of the register-file arbiter: requests, grants and shared read data.
interface regf_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          busy;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/regf_arbiter.sv
// Round-robin arbiter for the register file's single write/read port, with a post-reset zero-fill sweep.
// Define REGF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module regf_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regf_arbiter_if.slave         bus,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [ADDR_WIDTH-1:0] rf_r_addr,
  output logic [DATA_WIDTH-1:0] rf_w_data,
  input  logic [DATA_WIDTH-1:0] rf_r_data
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {INIT, ARB} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] init_cnt_reg;
  logic [NUM_REQ-1:0]    rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [PTR_W-1:0]      start_idx;
  logic [PTR_W-1:0]      win_idx;
  logic                  found;
  logic                  grant_valid;
  logic                  win_we;
  int                    scan_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign bus.gnt[gi]   = grant_valid && (win_idx == PTR_W'(gi));
    end
  endgenerate

`ifdef REGF_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  assign start_idx = ptr_reg;
  assign ptr_next  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
`endif

  // First requester at or after start_idx, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(start_idx) + k) % NUM_REQ;
      if (!found && bus.req[scan_idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(scan_idx);
      end
    end
  end

  assign grant_valid = !reset && (state_reg == ARB) && found;
  assign win_we      = bus.we[win_idx];
  assign bus.busy    = reset || (state_reg == INIT);
  assign bus.rvalid  = rvalid_reg;
  assign bus.rdata   = rdata_reg;

  always_comb begin
    rf_wr_en  = 1'b0;
    rf_w_addr = '0;
    rf_w_data = '0;
    rf_r_addr = '0;
    if (!reset && state_reg == INIT) begin
      rf_wr_en  = 1'b1;
      rf_w_addr = init_cnt_reg;
    end else if (grant_valid) begin
      if (win_we) begin
        rf_wr_en  = 1'b1;
        rf_w_addr = addr_arr[win_idx];
        rf_w_data = wdata_arr[win_idx];
      end else begin
        rf_r_addr = addr_arr[win_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      rvalid_reg   <= '0;
      rdata_reg    <= '0;
`ifndef REGF_ARB_FIXED_PRIO_EN
      ptr_reg      <= '0;
`endif
    end else begin
      rvalid_reg <= '0;
      case (state_reg)
        INIT: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (&init_cnt_reg) state_reg <= ARB;
        end
        ARB: begin
          if (grant_valid) begin
`ifndef REGF_ARB_FIXED_PRIO_EN
            ptr_reg <= ptr_next;
`endif
            // Register file read is combinational, so capture it at the grant edge.
            if (!win_we) begin
              rvalid_reg <= bus.gnt;
              rdata_reg  <= rf_r_data;
            end
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end
endmodule
